// File: rtl/mux_pkg.sv
// Shared constants for the 8-to-1 word-select mux.
// Select width, input count and default data width live here.
package mux_pkg;
    localparam int MUX_SEL_W  = 3;
    localparam int MUX_N      = 8;
    localparam int MUX_DATA_W = 3;
endpackage

// File: rtl/mux_8_1_comb.sv
// Purpose: combinational 8-to-1 word select, decoded as an if / else-if chain.
// Latency: zero cycles (pure combinational).
// Backpressure: none; no handshake.
module mux_8_1_comb
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DATA_W
) (
    input  logic [MUX_SEL_W-1:0] s,
    input  logic [WIDTH-1:0]     d0,
    input  logic [WIDTH-1:0]     d1,
    input  logic [WIDTH-1:0]     d2,
    input  logic [WIDTH-1:0]     d3,
    input  logic [WIDTH-1:0]     d4,
    input  logic [WIDTH-1:0]     d5,
    input  logic [WIDTH-1:0]     d6,
    input  logic [WIDTH-1:0]     d7,
    output logic [WIDTH-1:0]     sel_data
);

    // The trailing else turns an unknown select into a known zero.
    always_comb begin
        sel_data = '0;
        if (s == 3'd0)
            sel_data = d0;
        else if (s == 3'd1)
            sel_data = d1;
        else if (s == 3'd2)
            sel_data = d2;
        else if (s == 3'd3)
            sel_data = d3;
        else if (s == 3'd4)
            sel_data = d4;
        else if (s == 3'd5)
            sel_data = d5;
        else if (s == 3'd6)
            sel_data = d6;
        else if (s == 3'd7)
            sel_data = d7;
        else
            sel_data = '0;
    end

endmodule

// File: rtl/mux_8_1_if.sv
// Purpose: registered 8-to-1 word-select stage between datapath blocks.
// Latency: one clk cycle from s/d0..d7 to y; async reset clears y at once.
// Backpressure: none; y reloads on every rising edge.
module mux_8_1_if
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MUX_SEL_W-1:0] s,
    input  logic [WIDTH-1:0]     d0,
    input  logic [WIDTH-1:0]     d1,
    input  logic [WIDTH-1:0]     d2,
    input  logic [WIDTH-1:0]     d3,
    input  logic [WIDTH-1:0]     d4,
    input  logic [WIDTH-1:0]     d5,
    input  logic [WIDTH-1:0]     d6,
    input  logic [WIDTH-1:0]     d7,
    output logic [WIDTH-1:0]     y
);

    logic [WIDTH-1:0] sel_data;

    mux_8_1_comb #(
        .WIDTH(WIDTH)
    ) u_comb (
        .s        (s),
        .d0       (d0),
        .d1       (d1),
        .d2       (d2),
        .d3       (d3),
        .d4       (d4),
        .d5       (d5),
        .d6       (d6),
        .d7       (d7),
        .sel_data (sel_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            y <= '0;
        else
            y <= sel_data;
    end

endmodule

// File: tb/tb_mux_8_1_if.sv
// Bench for mux_8_1_if: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against an array-indexing model.
module tb_mux_8_1_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] s   = 3'd0;
    logic [2:0] dv [8];
    logic [2:0] y;
    logic [2:0] model_y;
    logic       run_cmp = 1'b0;

    int checks   = 0;
    int failures = 0;

    mux_8_1_if #(.WIDTH(3)) dut (
        .clk (clk),
        .rst (rst),
        .s   (s),
        .d0  (dv[0]),
        .d1  (dv[1]),
        .d2  (dv[2]),
        .d3  (dv[3]),
        .d4  (dv[4]),
        .d5  (dv[5]),
        .d6  (dv[6]),
        .d7  (dv[7]),
        .y   (y)
    );

    always #5 clk = ~clk;

    // Reference: y is the word the select pointed at on the previous edge.
    always @(posedge clk or posedge rst) begin
        if (rst)
            model_y <= 3'd0;
        else if ($isunknown(s))
            model_y <= 3'd0;
        else
            model_y <= dv[s];
    end

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: y=%b expected=%b at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (run_cmp)
            check("model", y, model_y);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_sweep();
        for (int i = 0; i < 8; i++) dv[i] = 3'(i);
    endtask

    initial begin
        int  sel8;
        logic [2:0] alt;

        for (int i = 0; i < 8; i++) dv[i] = 3'd0;
        #1;
        rst = 1'b1;
        #1;
        check("reset_state", y, 3'd0);
        load_sweep();
        #20;
        check("reset_held", y, 3'd0);
        @(negedge clk);
        rst = 1'b0;
        run_cmp = 1'b1;
        #1;

        // Sweep: y follows s one cycle later
        for (int k = 0; k < 8; k++) begin
            s = 3'(k);
            tick();
            check($sformatf("sweep_s%0d", k), y, 3'(k));
        end

        // Select value 8 truncates to 0
        sel8 = 8;
        s = 3'd6;
        tick();
        s = sel8[2:0];
        tick();
        check("wrap_8_to_d0", y, 3'd0);

        // Async reset mid-sweep at s=5
        s = 3'd4;
        tick();
        s = 3'd5;
        #2;
        check("pre_reset_y4", y, 3'd4);
        rst = 1'b1;
        #1;
        check("reset_immediate", y, 3'd0);
        rst = 1'b0;
        tick();
        check("after_reset_s5", y, 3'd5);

        // Data change on the selected input
        s = 3'd3;
        tick();
        check("data_d3_old", y, 3'b011);
        dv[3] = 3'b110;
        tick();
        check("data_d3_new", y, 3'b110);
        dv[0] = 3'b111; dv[1] = 3'b101; dv[7] = 3'b001;
        tick();
        check("data_others_ignored", y, 3'b110);

        // Unknown select resolves to zero
        for (int i = 0; i < 8; i++) dv[i] = 3'd0;
        s = 3'bxxx;
        tick();
        check("unknown_sel", y, 3'd0);

        // Back-to-back alternation
        dv[0] = 3'b000;
        dv[7] = 3'b111;
        for (int i = 0; i < 8; i++) begin
            alt = (i % 2 == 1) ? 3'd7 : 3'd0;
            s = alt;
            tick();
            check($sformatf("alternate_%0d", i), y, (i % 2 == 1) ? 3'b111 : 3'b000);
        end

        // Randomized traffic with occasional async reset pulses
        for (int n = 0; n < 400; n++) begin
            s = 3'($urandom_range(0, 7));
            for (int i = 0; i < 8; i++) dv[i] = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 19) == 0) begin
                #2;
                rst = 1'b1;
                #1;
                check("rand_reset", y, 3'd0);
                rst = 1'b0;
            end
            tick();
        end

        @(negedge clk);
        run_cmp = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
